// File: rtl/pe_array_feeder.sv
// Initiator for the PE multicast chain: clears the array, loads one weight per PE
// in chain order, broadcasts feature beats, then counts results until the job ends.
module pe_array_feeder #(
    parameter int QUAN_BITS = 8,
    parameter int NUM_PE    = 9,
    parameter int MAX_PIX   = 1024,
    parameter int CW        = $clog2(MAX_PIX + 1)
) (
    input  logic                 s_clk,
    input  logic                 s_rst,
    input  logic                 cfg_start,
    input  logic [CW-1:0]        cfg_pix_num,
    input  logic                 w_valid,
    input  logic [QUAN_BITS-1:0] w_data,
    output logic                 w_ready,
    input  logic                 f_valid,
    input  logic [QUAN_BITS-1:0] f_data,
    output logic                 f_ready,
    output logic                 pe_clr,
    output logic [NUM_PE-1:0]    pe_k_weight_valid,
    output logic [QUAN_BITS-1:0] pe_kernel_weight,
    output logic                 pe_f_data_valid,
    output logic [QUAN_BITS-1:0] pe_feature_data,
    input  logic                 rlst_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 err_overflow
);

    localparam int KW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam logic [NUM_PE-1:0] ONE_HOT0 = NUM_PE'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    state_t                r_state, w_next;
    logic [CW-1:0]         r_pix_num;
    logic [CW-1:0]         r_sent;
    logic [CW-1:0]         r_rcv;
    logic [KW-1:0]         r_wcnt;
    logic                  r_err;
    logic                  r_pe_clr;
    logic                  r_done;
    logic [NUM_PE-1:0]     r_kwv;
    logic [QUAN_BITS-1:0]  r_kw;
    logic                  r_fdv;
    logic [QUAN_BITS-1:0]  r_fd;
    logic                  w_w_hs;
    logic                  w_f_hs;
    logic                  w_counting;

    assign w_ready = (r_state == S_LOAD_W);
    assign f_ready = (r_state == S_STREAM) && (r_sent < r_pix_num);
    assign w_w_hs  = w_valid && w_ready;
    assign w_f_hs  = f_valid && f_ready;
    assign busy    = (r_state != S_IDLE);

    // Results are legal only between CLR and DRAIN; anything else is an overflow.
    assign w_counting = (r_state == S_CLR) || (r_state == S_LOAD_W) ||
                        (r_state == S_STREAM) || (r_state == S_DRAIN);

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (cfg_start) w_next = S_CLR;
            S_CLR:    w_next = S_LOAD_W;
            S_LOAD_W: if (w_w_hs && r_wcnt == KW'(NUM_PE - 1))
                          w_next = (r_pix_num == '0) ? S_DRAIN : S_STREAM;
            S_STREAM: if (w_f_hs && r_sent == r_pix_num - CW'(1)) w_next = S_DRAIN;
            S_DRAIN:  if (r_rcv == r_pix_num) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_pix_num <= '0;
            r_sent    <= '0;
            r_rcv     <= '0;
            r_wcnt    <= '0;
            r_err     <= 1'b0;
            r_pe_clr  <= 1'b0;
            r_done    <= 1'b0;
            r_kwv     <= '0;
            r_kw      <= '0;
            r_fdv     <= 1'b0;
            r_fd      <= '0;
        end else begin
            r_pe_clr <= (w_next == S_CLR);
            r_done   <= (w_next == S_DONE);

            r_kwv <= w_w_hs ? (ONE_HOT0 << r_wcnt) : '0;
            if (w_w_hs) begin
                r_kw   <= w_data;
                r_wcnt <= r_wcnt + KW'(1);
            end

            r_fdv <= w_f_hs;
            if (w_f_hs) begin
                r_fd   <= f_data;
                r_sent <= r_sent + CW'(1);
            end

            if (rlst_valid) begin
                if (w_counting && r_rcv != r_pix_num) r_rcv <= r_rcv + CW'(1);
                else                                  r_err <= 1'b1;
            end

            // Job start wins over any stray result in the same cycle.
            if (r_state == S_IDLE && cfg_start) begin
                r_pix_num <= cfg_pix_num;
                r_sent    <= '0;
                r_rcv     <= '0;
                r_wcnt    <= '0;
                r_err     <= 1'b0;
            end
        end
    end

    assign pe_clr            = r_pe_clr;
    assign done              = r_done;
    assign err_overflow      = r_err;
    assign pe_k_weight_valid = r_kwv;
    assign pe_kernel_weight  = r_kw;
    assign pe_f_data_valid   = r_fdv;
    assign pe_feature_data   = r_fd;

endmodule

// File: tb/tb_pe_array_feeder.sv
// Directed bench for pe_array_feeder: full job, random gaps, empty job,
// ignored start, overflow and mid-job reset.
module tb_pe_array_feeder;

    localparam int QB = 8;
    localparam int NP = 9;
    localparam int CW = 11;

    logic          s_clk = 1'b0;
    logic          s_rst;
    logic          cfg_start;
    logic [CW-1:0] cfg_pix_num;
    logic          w_valid, f_valid;
    logic [QB-1:0] w_data, f_data;
    logic          w_ready, f_ready;
    logic          pe_clr, pe_f_data_valid, busy, done, err_overflow;
    logic [NP-1:0] pe_k_weight_valid;
    logic [QB-1:0] pe_kernel_weight, pe_feature_data;
    logic          rlst_valid, rlst_man, auto_ret;
    logic [1:0]    rpipe;

    int checks = 0;
    int errors = 0;

    pe_array_feeder #(.QUAN_BITS(QB), .NUM_PE(NP), .MAX_PIX(1024)) dut (
        .s_clk(s_clk), .s_rst(s_rst), .cfg_start(cfg_start), .cfg_pix_num(cfg_pix_num),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .f_valid(f_valid), .f_data(f_data), .f_ready(f_ready),
        .pe_clr(pe_clr), .pe_k_weight_valid(pe_k_weight_valid),
        .pe_kernel_weight(pe_kernel_weight), .pe_f_data_valid(pe_f_data_valid),
        .pe_feature_data(pe_feature_data), .rlst_valid(rlst_valid),
        .busy(busy), .done(done), .err_overflow(err_overflow)
    );

    always #5 s_clk = ~s_clk;

    // Model of the PE chain tail: each feature beat returns a result 2 cycles later.
    always @(posedge s_clk) rpipe <= {rpipe[0], pe_f_data_valid};
    assign rlst_valid = rlst_man | (auto_ret & rpipe[1]);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge s_clk);
        #1;
    endtask

    task automatic start_job(input int pix);
        cfg_pix_num = CW'(pix);
        cfg_start   = 1'b1;
        tick();
        cfg_start   = 1'b0;
    endtask

    // Called one cycle after start (in CLR); returns in the cycle after the last weight strobe.
    task automatic load_weights(input string tag);
        logic [NP-1:0] exp_kwv;
        logic [QB-1:0] wv;
        w_valid = 1'b1;
        tick();
        chk({tag, "_wready"}, w_ready, 1);
        chk({tag, "_kwv_idle"}, pe_k_weight_valid, 0);
        for (int k = 0; k < NP; k++) begin
            wv      = QB'(k * 37 - 100);
            w_data  = wv;
            exp_kwv = NP'(1) << k;
            tick();
            chk({tag, "_kwv"}, pe_k_weight_valid, exp_kwv);
            chk({tag, "_kw"}, pe_kernel_weight, wv);
        end
        w_valid = 1'b0;
        tick_none();
    endtask

    task automatic tick_none();
    endtask

    task automatic stream(input string tag, input int n);
        logic [QB-1:0] fv;
        f_valid = 1'b1;
        for (int j = 0; j < n; j++) begin
            fv     = QB'(j * 53 + 7);
            f_data = fv;
            tick();
            chk({tag, "_fdv"}, pe_f_data_valid, 1);
            chk({tag, "_fd"}, pe_feature_data, fv);
        end
        f_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int            n, k, j;
        logic          hs;
        logic [QB-1:0] dv;
        logic [NP-1:0] exp_kwv;

        s_rst = 1'b1; cfg_start = 1'b0; cfg_pix_num = '0;
        w_valid = 1'b0; f_valid = 1'b0; w_data = '0; f_data = '0;
        rlst_man = 1'b0; auto_ret = 1'b0;
        #1;
        chk("rst_outs", {w_ready, f_ready, pe_clr, pe_f_data_valid, busy, done, err_overflow}, 0);
        chk("rst_buses", {pe_k_weight_valid, pe_kernel_weight, pe_feature_data}, 0);
        @(negedge s_clk); @(negedge s_clk);
        s_rst = 1'b0;

        // Job 1: pix=4, valids held high, results 2 cycles after each beat
        auto_ret = 1'b1;
        start_job(4);
        chk("j1_clr", pe_clr, 1);
        chk("j1_busy", busy, 1);
        load_weights("j1");
        chk("j1_fready", f_ready, 1);
        chk("j1_wready_off", w_ready, 0);
        stream("j1", 4);
        chk("j1_fready_off", f_ready, 0);
        chk("j1_clr_once", pe_clr, 0);
        wait_done(n);
        chk("j1_done_lat", n, 4);
        chk("j1_busy_at_done", busy, 1);
        tick();
        chk("j1_done_pulse", done, 0);
        chk("j1_busy_fall", busy, 0);
        chk("j1_err", err_overflow, 0);

        // Job 2: random valid gaps, pix=16
        start_job(16);
        chk("j2_clr", pe_clr, 1);
        tick();
        k = 0; n = 0;
        while (k < NP && n < 200) begin
            chk("j2_wready", w_ready, 1);
            w_valid = 1'($urandom_range(0, 1));
            dv      = QB'($urandom_range(0, 255));
            w_data  = dv;
            hs      = w_valid;
            exp_kwv = NP'(1) << k;
            tick();
            if (hs) begin
                chk("j2_kwv", pe_k_weight_valid, exp_kwv);
                chk("j2_kw", pe_kernel_weight, dv);
                k++;
            end else begin
                chk("j2_kwv_gap", pe_k_weight_valid, 0);
            end
            n++;
        end
        w_valid = 1'b0;
        chk("j2_wbound", k, NP);
        j = 0; n = 0;
        while (j < 16 && n < 300) begin
            chk("j2_fready", f_ready, 1);
            f_valid = 1'($urandom_range(0, 1));
            dv      = QB'($urandom_range(0, 255));
            f_data  = dv;
            hs      = f_valid;
            tick();
            chk("j2_fdv", pe_f_data_valid, hs);
            if (hs) begin
                chk("j2_fd", pe_feature_data, dv);
                j++;
            end
            n++;
        end
        f_valid = 1'b0;
        chk("j2_fbound", j, 16);
        chk("j2_fready_off", f_ready, 0);
        wait_done(n);
        chk("j2_done", done, 1);
        tick();
        chk("j2_idle", busy, 0);
        chk("j2_err", err_overflow, 0);

        // Job 3: pix=0 goes straight to DRAIN then DONE
        start_job(0);
        load_weights("j3");
        chk("j3_fready", f_ready, 0);
        chk("j3_nodone", done, 0);
        tick();
        chk("j3_done", done, 1);
        chk("j3_fready2", f_ready, 0);
        tick();
        chk("j3_idle", busy, 0);

        // Job 4: cfg_start during STREAM is ignored
        start_job(3);
        load_weights("j4");
        stream("j4a", 1);
        cfg_start = 1'b1; cfg_pix_num = CW'(7);
        stream("j4b", 1);
        cfg_start = 1'b0;
        stream("j4c", 1);
        chk("j4_fready_off", f_ready, 0);
        wait_done(n);
        chk("j4_done", done, 1);
        chk("j4_err", err_overflow, 0);
        tick();
        chk("j4_idle", busy, 0);

        // Job 5: extra result after the last one, then one in IDLE
        start_job(4);
        load_weights("j5");
        stream("j5", 4);
        tick(); tick(); tick();
        chk("j5_no_err_yet", err_overflow, 0);
        rlst_man = 1'b1;
        tick();
        rlst_man = 1'b0;
        chk("j5_done", done, 1);
        chk("j5_err", err_overflow, 1);
        tick();
        chk("j5_err_sticky", err_overflow, 1);
        rlst_man = 1'b1;
        tick();
        rlst_man = 1'b0;
        chk("j5_err_idle", err_overflow, 1);
        tick();

        // Job 6: start clears error; reset after the 2nd feature beat
        auto_ret = 1'b0;
        start_job(4);
        chk("j6_err_clr", err_overflow, 0);
        load_weights("j6");
        stream("j6", 2);
        f_valid = 1'b1;
        #2;
        s_rst = 1'b1;
        #1;
        chk("j6_rst_outs", {w_ready, f_ready, pe_clr, pe_f_data_valid, busy, done, err_overflow}, 0);
        chk("j6_rst_buses", {pe_k_weight_valid, pe_kernel_weight, pe_feature_data}, 0);
        f_valid = 1'b0;
        @(negedge s_clk);
        s_rst = 1'b0;
        tick();
        chk("j6_idle", busy, 0);
        chk("j6_no_clr", pe_clr, 0);

        // Job 7: clean run after reset
        auto_ret = 1'b1;
        start_job(2);
        chk("j7_clr", pe_clr, 1);
        load_weights("j7");
        stream("j7", 2);
        wait_done(n);
        chk("j7_done", done, 1);
        chk("j7_err", err_overflow, 0);
        tick();
        chk("j7_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
